// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a registered winner index and a
// decoded one-hot grant. Optional hold timeout enabled by RR_ARB_TIMEOUT_EN.
module rr_arbiter_16 #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        preempt
);

    typedef enum logic {IDLE, GRANT} state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter_16: HOLD_MAX must be in 2..255");
    end

    // First set bit of r, scanning upward from start and wrapping 15 -> 0.
    function automatic pick_t find_next(logic [15:0] r, logic [3:0] start);
        pick_t      p;
        logic [3:0] idx;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (r[idx] && !p.found) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [3:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       preempt_q, preempt_d;

    pick_t      idle_pick;
    pick_t      next_pick;
    logic [3:0] after_holder;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HCNT_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hcnt_q, hcnt_d;
`endif

    assign after_holder = gnt_idx_q + 4'd1;
    assign idle_pick    = find_next(req, ptr_q);
    // The holder's own bit is masked so a forced rotation never re-picks it.
    assign next_pick    = find_next(req & ~(16'd1 << gnt_idx_q), after_holder);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hcnt_d      = hcnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (idle_pick.found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = idle_pick.idx;
                    gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    hcnt_d      = '0;
`endif
                end
            end

            GRANT: begin
                if (!req[gnt_idx_q]) begin
                    ptr_d = after_holder;
                    if (next_pick.found) begin
                        gnt_idx_d = next_pick.idx;
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    hcnt_d = '0;
`endif
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    if (hcnt_q == HCNT_LAST) begin
                        // Rotate only when someone else is waiting; otherwise hcnt stays saturated.
                        if (next_pick.found) begin
                            gnt_idx_d = next_pick.idx;
                            ptr_d     = after_holder;
                            preempt_d = 1'b1;
                            hcnt_d    = '0;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 8'd1;
                    end
`endif
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (gnt_valid_q) begin
            gnt[gnt_idx_q] = 1'b1;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16; the timeout section adapts to RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_16;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    int checks = 0;
    int errors = 0;

    rr_arbiter_16 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_grant(input string tag, input logic [3:0] idx);
        logic [15:0] onehot;
        onehot = 16'd1 << idx;
        check({tag, "_gnt"}, gnt, onehot);
        check({tag, "_idx"}, {12'd0, gnt_idx}, {12'd0, idx});
        check({tag, "_valid"}, {15'd0, gnt_valid}, 16'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, gnt, 16'h0000);
        check({tag, "_valid"}, {15'd0, gnt_valid}, 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 16'h0000;
        step();
        step();
        check("rst_gnt", gnt, 16'h0000);
        check("rst_idx", {12'd0, gnt_idx}, 16'd0);
        check("rst_valid", {15'd0, gnt_valid}, 16'd0);
        check("rst_preempt", {15'd0, preempt}, 16'd0);
        reset = 1'b0;

        // No requests: stays idle.
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("idle");
        end

        // Two requesters from reset: 0 first, then 15, then idle (ptr ends at 0).
        req = 16'h8001;
        step();
        check_grant("first0", 4'd0);
        req = 16'h8000;
        step();
        check_grant("hand15", 4'd15);
        req = 16'h0000;
        step();
        check_idle("rel15");

        // All request; each holder drops its own bit for one cycle.
        req = 16'hFFFF;
        step();
        check_grant("ring0", 4'd0);
        for (int k = 0; k < 16; k++) begin
            logic [15:0] drop;
            logic [3:0]  nxt;
            drop = 16'd1 << k;
            nxt  = 4'(k + 1);
            req  = 16'hFFFF & ~drop;
            step();
            check_grant("ring", nxt);
            check("ring_onehot", 16'($countones(gnt)), 16'd1);
        end
        req = 16'h0000;
        step();
        check_idle("ring_rel");

        // Move ptr to 5 via requester 4, then check wrap order 0 before 4.
        req = 16'h0010;
        step();
        check_grant("p4", 4'd4);
        req = 16'h0000;
        step();
        check_idle("p4_rel");
        req = 16'h0011;
        step();
        check_grant("wrap0", 4'd0);
        req = 16'h0010;
        step();
        check_grant("then4", 4'd4);
        req = 16'h0000;
        step();
        check_idle("wrap_rel");

        // Hold behaviour: requester 3 holds while 7 waits.
        req = 16'h0008;
        step();
        check_grant("h3", 4'd3);
        req = 16'h0088;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant("hold3", 4'd3);
            check("hold3_pre", {15'd0, preempt}, 16'd0);
        end
        step();
        check_grant("rot7", 4'd7);
        check("rot7_pre", {15'd0, preempt}, 16'd1);
        step();
        check_grant("keep7", 4'd7);
        check("keep7_pre", {15'd0, preempt}, 16'd0);
        req = 16'h0008;
        step();
        check_grant("back3", 4'd3);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check_grant("hold3", 4'd3);
            check("hold3_pre", {15'd0, preempt}, 16'd0);
        end
        req = 16'h0008;
`endif
        // Sole requester is never preempted.
        for (int i = 0; i < 10; i++) begin
            step();
            check_grant("solo3", 4'd3);
            check("solo3_pre", {15'd0, preempt}, 16'd0);
        end
        req = 16'h0000;
        step();
        check_idle("solo_rel");

        // Reset while granting 9.
        req = 16'h0200;
        step();
        check_grant("g9", 4'd9);
        reset = 1'b1;
        step();
        check("mrst_gnt", gnt, 16'h0000);
        check("mrst_idx", {12'd0, gnt_idx}, 16'd0);
        check("mrst_valid", {15'd0, gnt_valid}, 16'd0);
        check("mrst_preempt", {15'd0, preempt}, 16'd0);
        reset = 1'b0;
        step();
        check_grant("g9_again", 4'd9);

        // Reset again: ptr back at 0 means 0 beats 9.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 16'h0201;
        step();
        check_grant("ptr0", 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
